// File: rtl/seq_mul_16_bit_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// default operand width and the iteration-counter width derivation.
package seq_mul_16_bit_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest counter width whose range exceeds the operand width.
    function automatic int calc_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mul_16_bit_if.sv
// Request/result bundle between the multiplier and its requester.
interface seq_mul_16_bit_if #(
    parameter int WIDTH = seq_mul_16_bit_pkg::DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, product, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, ovf
    );

endinterface

// File: rtl/seq_mul_16_bit_datapath.sv
// Shift-add datapath: accumulator, multiplicand/multiplier shift registers and adder.
// Optional SEQ_MUL_EARLY_EXIT_EN adds the "remaining multiplier is zero" flag.
module seq_mul_datapath #(
    parameter int WIDTH = seq_mul_16_bit_pkg::DEF_WIDTH
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MUL_EARLY_EXIT_EN
    output logic               mplr_rest_zero,
`endif
    output logic [2*WIDTH-1:0] sum
);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplr_r;

    // Full-width partial-product add, no truncation.
    always_comb begin
        sum = acc_r;
        if (mplr_r[0]) begin
            sum = acc_r + mcand_r;
        end else begin
            sum = acc_r;
        end
    end

`ifdef SEQ_MUL_EARLY_EXIT_EN
    assign mplr_rest_zero = ((mplr_r >> 1) == {WIDTH{1'b0}});
`endif

    // Operand capture on load, one shift-add iteration per step.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc_r   <= {(2*WIDTH){1'b0}};
            mcand_r <= {(2*WIDTH){1'b0}};
            mplr_r  <= {WIDTH{1'b0}};
        end else if (load) begin
            acc_r   <= {(2*WIDTH){1'b0}};
            mcand_r <= {{WIDTH{1'b0}}, a};
            mplr_r  <= b;
        end else if (step) begin
            acc_r   <= sum;
            mcand_r <= mcand_r << 1;
            mplr_r  <= mplr_r >> 1;
        end else begin
            acc_r   <= acc_r;
            mcand_r <= mcand_r;
            mplr_r  <= mplr_r;
        end
    end

endmodule

// File: rtl/seq_mul_16_bit.sv
// Iterative unsigned multiplier top: FSM, iteration counter and held result registers.
// Optional SEQ_MUL_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are zero.
module seq_mul_16_bit
    import seq_mul_16_bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = calc_cnt_w(WIDTH)
) (
    input  logic              clk,
    input  logic              clr_n,
    seq_mul_16_bit_if.slave   bus
);

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               load_s;
    logic               step_s;
    logic               last_s;
    logic               early_s;
    logic [2*WIDTH-1:0] sum_s;
    logic [WIDTH-1:0]   product_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;

`ifdef SEQ_MUL_EARLY_EXIT_EN
    logic               mplr_rest_zero_s;
    assign early_s = mplr_rest_zero_s;
`else
    assign early_s = 1'b0;
`endif

    seq_mul_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk            (clk),
        .clr_n          (clr_n),
        .load           (load_s),
        .step           (step_s),
        .a              (bus.a),
        .b              (bus.b),
`ifdef SEQ_MUL_EARLY_EXIT_EN
        .mplr_rest_zero (mplr_rest_zero_s),
`endif
        .sum            (sum_s)
    );

    // Next-state and datapath strobe decode.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    load_s       = 1'b1;
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if ((cnt_r == CNT_W'(WIDTH - 1)) || early_s) begin
                    last_s       = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, counter and result registers; busy/done registered from next state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            product_r <= {WIDTH{1'b0}};
            ovf_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != IDLE);
            done_r  <= (next_state_s == DONE);
            if (load_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (step_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (last_s) begin
                product_r <= sum_s[WIDTH-1:0];
                ovf_r     <= |sum_s[2*WIDTH-1:WIDTH];
            end else begin
                product_r <= product_r;
                ovf_r     <= ovf_r;
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
    assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_seq_mul_16_bit.sv
// Scoreboard bench for seq_mul_16_bit: driver queues expected results, monitor checks each done.
module tb_seq_mul_16_bit;

    typedef struct {
        logic [15:0] prod;
        logic        ovf;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic clk;
    logic clr_n;
    int   cyc;
    int   pass_cnt;
    int   total_cnt;
    exp_t sb_q[$];
    logic [15:0] load_reg;

    seq_mul_16_bit_if #(.WIDTH(16)) bus ();

    seq_mul_16_bit dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Downstream LOAD register fed by product/done.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) load_reg <= 16'h0000;
        else if (bus.done) load_reg <= bus.product;
        else load_reg <= load_reg;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (act === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic int exp_lat(input logic [15:0] bv);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        int l;
        l = 1;
        for (int i = 0; i < 16; i++) if (bv[i]) l = i + 1;
        return l;
`else
        return 16;
`endif
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("product", {16'h0, bus.product}, {16'h0, e.prod});
                    check("ovf", {31'h0, bus.ovf}, {31'h0, e.ovf});
                    check("done_latency", cyc - e.acc_cyc, e.lat);
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv,
                          input logic [15:0] ep, input logic eo, input bit inj);
        exp_t e;
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = ta;
        bus.b = tbv;
        @(negedge clk);
        e.prod = ep;
        e.ovf = eo;
        e.lat = exp_lat(tbv);
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        bus.start = 1'b0;
        bus.a = 16'hDEAD;
        bus.b = 16'hBEEF;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            if (inj && n == 3) begin
                bus.start = 1'b1;
                bus.a = 16'h0001;
                bus.b = 16'h0001;
            end
            if (inj && n == 4) bus.start = 1'b0;
            n = n + 1;
            @(negedge clk);
        end
        check("busy_cycles", n, e.lat + 1);
        check("queue_drained", sb_q.size(), 0);
        repeat (3) @(negedge clk);
        check("product_held", {16'h0, bus.product}, {16'h0, ep});
        check("done_low_after", {31'h0, bus.done}, 32'd0);
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        bus.start = 1'b0;
        bus.a = 16'h0000;
        bus.b = 16'h0000;
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, bus.busy}, 32'd0);
        check("rst_done", {31'h0, bus.done}, 32'd0);
        check("rst_product", {16'h0, bus.product}, 32'd0);
        check("rst_ovf", {31'h0, bus.ovf}, 32'd0);
        clr_n = 1'b1;
        @(negedge clk);

        run_op(16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        run_op(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
        run_op(16'h0007, 16'h0009, 16'h003F, 1'b0, 1'b1);
        run_op(16'h0006, 16'h0007, 16'h002A, 1'b0, 1'b0);
        check("load_reg_capture", {16'h0, load_reg}, 32'h0000_002A);
        repeat (4) @(negedge clk);
        check("load_reg_hold", {16'h0, load_reg}, 32'h0000_002A);

        // Abort mid-run: outputs clear at once and no done follows.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 16'h1234;
        bus.b = 16'h0002;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        #1 clr_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, bus.busy}, 32'd0);
        check("abort_done", {31'h0, bus.done}, 32'd0);
        check("abort_product", {16'h0, bus.product}, 32'd0);
        check("abort_ovf", {31'h0, bus.ovf}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_idle", {31'h0, bus.busy}, 32'd0);

        run_op(16'h0002, 16'h0002, 16'h0004, 1'b0, 1'b0);
        run_op(16'h00AB, 16'h0001, 16'h00AB, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0);
        run_op(16'h0001, 16'h8000, 16'h8000, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("final_queue_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_mul_16_bit.md
Name: seq_mul_16_bit

Overview:
- Iterative unsigned shift-add multiplier for the 16-bit datapath.
- Sits directly upstream of the 16-bit LOAD register: `product` drives the register's D input and `done` drives its LOAD.
- Used for MUL-class instructions that stall the core while `busy` is high.
- Produces the low WIDTH bits of the product plus an overflow flag.

Parameters:
- WIDTH, 16, operand/product width in bits (minimum 2).
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand; captured when start is accepted.
- b  input  WIDTH  multiplier; captured when start is accepted.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; product/ovf valid; wire to downstream LOAD.
- product  output  WIDTH  low WIDTH bits of a*b; held until the next done.
- ovf  output  1  high if the upper WIDTH bits of the full product are nonzero; held with product.

Behaviour:
- Reset (clr_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0, product=0, ovf=0.
  - Internal accumulator (2*WIDTH bits), multiplicand shift register (2*WIDTH bits), multiplier shift register (WIDTH bits) and counter all cleared.
  - An in-flight operation is discarded; no done is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a posedge: mcand<={0,a}, mplr<=b, acc<=0, cnt<=0, go RUN.
  - start=0: stay in IDLE.
- RUN, each posedge:
  - If mplr[0]: acc<=acc+mcand, using full 2*WIDTH-bit add with no truncation.
  - mcand<=mcand<<1; mplr<=mplr>>1; cnt<=cnt+1.
  - When cnt==WIDTH-1 (last iteration): product<=low WIDTH bits of the final sum; ovf<=OR of its upper WIDTH bits; go DONE.
- DONE: done=1 for exactly this one cycle; next posedge returns to IDLE.
- Latency: start accepted at edge E0 → exactly WIDTH RUN cycles → done high in the cycle after edge E_WIDTH → busy low after edge E_WIDTH+1.
  - Fixed at 16+1 cycles of busy for WIDTH=16 (without the optional feature).
- start while busy (RUN or DONE) is ignored; no queuing.
  - Back-to-back throughput is one result per WIDTH+2 cycles.
- a and b may change freely after acceptance; captured copies are used.
- product/ovf change only on the DONE-entry edge or on reset; stable at all other times.
- Operands are unsigned only; no signed mode.

Optional Feature:
- Macro: SEQ_MUL_EARLY_EXIT_EN.
- Defined:
  - In RUN, if the shifted multiplier value becomes zero, the current iteration is the last one.
  - product/ovf update and the block goes DONE on that edge.
  - Latency = position of the highest set bit of b plus 1, minimum 1 RUN cycle (b=0 gives 1 RUN cycle, product=0).
  - Results are identical to the non-early-exit build.
- Undefined: fixed WIDTH-cycle RUN phase regardless of b; the early-exit comparator is not present.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH of 16;
  - the CNT_W derivation.
- One sub-module is natural: seq_mul_datapath. It holds acc, mcand and mplr, the adder and the shifters, and is driven by load/step strobes from the FSM in the top.
- FSM and counter stay in seq_mul_16_bit.

Test Plan:
- a=3, b=5, start pulsed one cycle → busy high for 17 cycles; done exactly once, 16 cycles after the accept edge; product=0x000F, ovf=0.
- a=0xFFFF, b=0xFFFF → product=0x0001, ovf=1. a=0x0100, b=0x0100 → product=0x0000, ovf=1.
- Accept a=7, b=9; pulse start again with a=1, b=1 while busy → single done, product=0x003F; second request ignored; product held after done.
- Accept a=0x1234, b=0x0002; pull clr_n low at RUN cycle 8 → outputs immediately 0, no done. New start with a=2, b=2 after release → product=0x0004.
- SEQ_MUL_EARLY_EXIT_EN defined: a=0x00AB, b=0x0001 → done after 1 RUN cycle, product=0x00AB. b=0 → done after 1 RUN cycle, product=0. b=0x8000, a=1 → 16 RUN cycles, product=0x8000.
- Chain to the downstream 16-bit LOAD register: a=6, b=7 → register captures 0x002A on the edge ending the done cycle, and holds it afterward.
